axi_wr_mux_nto1: RTL



---
 rtl/axi_mux_pkg.sv | 20 ++
 rtl/axi_wr_mux_nto1_if.sv | 51 +++++
 rtl/axi_id_fifo.sv | 51 +++++
 rtl/axi_wr_mux_nto1.sv | 113 +++++++++++
 4 files changed

// File: rtl/axi_mux_pkg.sv
// Shared constants, types and helpers for the N-to-1 AXI write multiplexer.
package axi_mux_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    typedef enum logic {
        ARB  = 1'b0,
        HOLD = 1'b1
    } arb_state_t;

    function automatic logic [2:0] f_axsize(input int data_width);
        return 3'($clog2(data_width / 8));
    endfunction

    // Source-index width; a single source still needs one bit to carry an index.
    function automatic int f_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi_wr_mux_nto1_if.sv
// Bundle of the N upstream write ports plus the single downstream write port.
// The master modport is the multiplexer's view; slave is the surrounding system's view.
interface axi_wr_mux_nto1_if #(
    parameter int N      = 4,
    parameter int ID_W   = 4,
    parameter int ADDR_W = 64,
    parameter int DATA_W = 512
);
    logic [N-1:0]          s_awvalid;
    logic [N-1:0]          s_awready;
    logic [N*ADDR_W-1:0]   s_awaddr;
    logic [N*8-1:0]        s_awlen;
    logic [N-1:0]          s_wvalid;
    logic [N-1:0]          s_wready;
    logic [N*DATA_W-1:0]   s_wdata;
    logic [N*DATA_W/8-1:0] s_wstrb;
    logic [N-1:0]          s_wlast;
    logic [N-1:0]          s_bvalid;
    logic [N-1:0]          s_bready;

    logic                  m_awvalid;
    logic                  m_awready;
    logic [ADDR_W-1:0]     m_awaddr;
    logic [7:0]            m_awlen;
    logic [1:0]            m_awburst;
    logic [2:0]            m_awsize;
    logic [ID_W-1:0]       m_awid;
    logic                  m_wvalid;
    logic                  m_wready;
    logic [DATA_W-1:0]     m_wdata;
    logic [DATA_W/8-1:0]   m_wstrb;
    logic                  m_wlast;
    logic                  m_bvalid;
    logic                  m_bready;

    modport master (
        input  s_awvalid, s_awaddr, s_awlen, s_wvalid, s_wdata, s_wstrb, s_wlast, s_bready,
        input  m_awready, m_wready, m_bvalid,
        output s_awready, s_wready, s_bvalid,
        output m_awvalid, m_awaddr, m_awlen, m_awburst, m_awsize, m_awid,
        output m_wvalid, m_wdata, m_wstrb, m_wlast, m_bready
    );

    modport slave (
        output s_awvalid, s_awaddr, s_awlen, s_wvalid, s_wdata, s_wstrb, s_wlast, s_bready,
        output m_awready, m_wready, m_bvalid,
        input  s_awready, s_wready, s_bvalid,
        input  m_awvalid, m_awaddr, m_awlen, m_awburst, m_awsize, m_awid,
        input  m_wvalid, m_wdata, m_wstrb, m_wlast, m_bready
    );
endinterface

// File: rtl/axi_id_fifo.sv
// Small synchronous FIFO of source indices; dout is the registered head, no bypass.
// Push while full and pop while empty are ignored.
module axi_id_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign dout_o  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        cnt_d    = cnt_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end
endmodule

// File: rtl/axi_wr_mux_nto1.sv
// N-to-1 AXI4 write mux: round-robin AW arbitration, W and B routed by per-burst index FIFOs.
// Zero data latency; AW blocked while either routing FIFO is full, W/B stall on the selected source.
module axi_wr_mux_nto1
    import axi_mux_pkg::*;
#(
    parameter int C_NUM_SLAVES       = 4,
    parameter int C_M_AXI_ID_WIDTH   = 4,
    parameter int C_M_AXI_ADDR_WIDTH = 64,
    parameter int C_M_AXI_DATA_WIDTH = 512,
    parameter int C_MAX_OUTSTANDING  = 8
) (
    input logic               clk,
    input logic               rst,
    axi_wr_mux_nto1_if.master axi
);
    localparam int N      = C_NUM_SLAVES;
    localparam int IDX_W  = f_idx_w(N);
    localparam int ADDR_W = C_M_AXI_ADDR_WIDTH;
    localparam int DATA_W = C_M_AXI_DATA_WIDTH;
    localparam int STRB_W = DATA_W / 8;

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] arb_idx, aw_sel;
    logic [IDX_W-1:0] w_head, b_head;
    logic             wfifo_full, wfifo_empty, bfifo_full, bfifo_empty;
    logic             fifo_full, aw_hs, w_pop, b_pop;

    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= N) sum = sum - N;
        return IDX_W'(sum);
    endfunction

    // Scan from the farthest candidate back to rr_ptr so the nearest requester wins.
    always_comb begin
        arb_idx = rr_ptr_q;
        for (int k = N - 1; k >= 0; k--) begin
            if (axi.s_awvalid[wrap_idx(rr_ptr_q, k)]) arb_idx = wrap_idx(rr_ptr_q, k);
        end
    end

    assign aw_sel        = (state_q == HOLD) ? grant_q : arb_idx;
    assign fifo_full     = wfifo_full | bfifo_full;
    assign axi.m_awvalid = axi.s_awvalid[aw_sel] & ~fifo_full;
    assign aw_hs         = axi.m_awvalid & axi.m_awready;
    assign axi.s_awready = aw_hs ? (N'(1) << aw_sel) : '0;
    assign axi.m_awaddr  = axi.s_awaddr[aw_sel*ADDR_W +: ADDR_W];
    assign axi.m_awlen   = axi.s_awlen[aw_sel*8 +: 8];
    assign axi.m_awburst = AXI_BURST_INCR;
    assign axi.m_awsize  = f_axsize(DATA_W);
    assign axi.m_awid    = '0;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        if (aw_hs) begin
            state_d  = ARB;
            rr_ptr_d = wrap_idx(aw_sel, 1);
        end else if (axi.m_awvalid && (state_q == ARB)) begin
            state_d = HOLD;
            grant_d = aw_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ARB;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign axi.m_wvalid = ~wfifo_empty & axi.s_wvalid[w_head];
    assign axi.m_wdata  = axi.s_wdata[w_head*DATA_W +: DATA_W];
    assign axi.m_wstrb  = axi.s_wstrb[w_head*STRB_W +: STRB_W];
    assign axi.m_wlast  = axi.s_wlast[w_head];
    assign axi.s_wready = wfifo_empty ? '0 : (N'(axi.m_wready) << w_head);
    assign w_pop        = axi.m_wvalid & axi.m_wready & axi.m_wlast;

    assign axi.m_bready = ~bfifo_empty & axi.s_bready[b_head];
    assign axi.s_bvalid = bfifo_empty ? '0 : (N'(axi.m_bvalid) << b_head);
    assign b_pop        = axi.m_bvalid & axi.m_bready;

    axi_id_fifo #(.WIDTH(IDX_W), .DEPTH(C_MAX_OUTSTANDING)) u_wfifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (aw_hs),
        .pop_i   (w_pop),
        .din_i   (aw_sel),
        .dout_o  (w_head),
        .full_o  (wfifo_full),
        .empty_o (wfifo_empty)
    );

    axi_id_fifo #(.WIDTH(IDX_W), .DEPTH(C_MAX_OUTSTANDING)) u_bfifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (aw_hs),
        .pop_i   (b_pop),
        .din_i   (aw_sel),
        .dout_o  (b_head),
        .full_o  (bfifo_full),
        .empty_o (bfifo_empty)
    );
endmodule
